// File: rtl/mul_seq.sv
// rtl/mul_seq.sv - 32x32 sequential shift-add multiplier, 33 cycles per product, 64-bit hi/lo result
module mul_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, state_next;
    logic [4:0]  cnt;
    logic [31:0] mcand;
    logic [31:0] acc;
    logic [31:0] mplier;
    logic        neg;

    logic [31:0] a_mag, b_mag;
    logic [32:0] sum;
    logic [63:0] prod;
    logic [63:0] result;

    // Negating 0x80000000 yields 0x80000000, which is the correct unsigned magnitude.
    assign a_mag = (is_signed && a[31]) ? -a : a;
    assign b_mag = (is_signed && b[31]) ? -b : b;

    // The final step's shifted value is the full product, so it is formed here and
    // loaded into hi/lo on the same edge that the last step retires.
    always_comb begin
        sum    = {1'b0, acc} + (mplier[0] ? {1'b0, mcand} : 33'd0);
        prod   = {sum, mplier[31:1]};
        result = neg ? -prod : prod;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: state_next = start ? RUN : IDLE;
            RUN:        if (cnt == 5'd31) state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= 5'd0;
            mcand  <= 32'd0;
            acc    <= 32'd0;
            mplier <= 32'd0;
            neg    <= 1'b0;
            hi     <= 32'd0;
            lo     <= 32'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        mcand  <= a_mag;
                        mplier <= b_mag;
                        acc    <= 32'd0;
                        cnt    <= 5'd0;
                        neg    <= is_signed & (a[31] ^ b[31]);
                    end
                end
                RUN: begin
                    acc    <= sum[32:1];
                    mplier <= {sum[0], mplier[31:1]};
                    cnt    <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        hi <= result[63:32];
                        lo <= result[31:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq.sv
// tb/tb_mul_seq.sv - table, random and corner-sequence bench for mul_seq
module tb_mul_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    mul_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
        longint      sx, sy;
        logic [63:0] ux, uy;
        if (s) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            return 64'(sx * sy);
        end
        ux = {32'd0, x};
        uy = {32'd0, y};
        return ux * uy;
    endfunction

    // Issues one multiply, scrambles the operand inputs after capture, then
    // checks busy length, done pulse, result and done width.
    task automatic mul_check(input logic [31:0] x, input logic [31:0] y, input logic s,
                             input logic [63:0] exp, input string nm);
        int nb;
        bit got;
        @(negedge clk);
        start = 1'b1; a = x; b = y; is_signed = s;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom; is_signed = 1'($urandom);
        nb = 0;
        got = 0;
        for (int k = 0; k < 40; k++) begin
            if (done) begin
                got = 1;
                break;
            end
            if (busy) nb++;
            @(negedge clk);
        end
        chk({nm, " busy_cycles"}, 64'(nb), 64'd32);
        chk({nm, " done_seen"}, 64'(got), 64'd1);
        chk({nm, " product"}, {hi, lo}, exp);
        @(negedge clk);
        chk({nm, " done_width"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        int n_done;
        int lat;
        logic [31:0] rx, ry;
        logic        rs;

        rst = 1'b1; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
        vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001, "u_max"});
        vecs.push_back('{32'hFFFFFFFD, 32'h00000005, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1, "s_m3x5"});
        vecs.push_back('{32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h00000000, "s_min_min"});
        vecs.push_back('{32'h80000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 32'h80000000, "s_min_one"});
        vecs.push_back('{32'h00000000, 32'h12345678, 1'b1, 32'h00000000, 32'h00000000, "zero_a"});
        vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h00000001, "s_m1_m1"});
        vecs.push_back('{32'h80000000, 32'h80000000, 1'b0, 32'h40000000, 32'h00000000, "u_msb_msb"});

        repeat (2) @(negedge clk);
        chk("reset busy", {63'd0, busy}, 64'd0);
        chk("reset done", {63'd0, done}, 64'd0);
        chk("reset hilo", {hi, lo}, 64'd0);
        rst = 1'b0;

        foreach (vecs[i]) mul_check(vecs[i].a, vecs[i].b, vecs[i].s, {vecs[i].hi, vecs[i].lo}, vecs[i].name);

        for (int i = 0; i < 20; i++) begin
            rx = $urandom; ry = $urandom; rs = 1'($urandom);
            if (i % 5 == 0) rx = 32'h80000000;
            if (i % 7 == 0) ry = 32'h7FFFFFFF;
            mul_check(rx, ry, rs, model(rx, ry, rs), $sformatf("rand%0d", i));
        end

        // start pulsed mid-RUN must be ignored
        @(negedge clk);
        start = 1'b1; a = 32'd7; b = 32'd6; is_signed = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
        @(negedge clk);
        start = 1'b0; a = 32'h5A5A5A5A;
        n_done = 0;
        for (int k = 0; k < 60; k++) begin
            if (done) begin
                n_done++;
                chk("run_start product", {hi, lo}, 64'd42);
            end
            @(negedge clk);
        end
        chk("run_start done_count", 64'(n_done), 64'd1);

        // reset mid-RUN aborts with no done pulse
        @(negedge clk);
        start = 1'b1; a = 32'h12345678; b = 32'h9ABCDEF0; is_signed = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort busy", {63'd0, busy}, 64'd0);
        chk("abort done", {63'd0, done}, 64'd0);
        chk("abort hilo", {hi, lo}, 64'd0);
        n_done = 0;
        for (int k = 0; k < 40; k++) begin
            if (done) n_done++;
            @(negedge clk);
        end
        chk("abort done_count", 64'(n_done), 64'd0);
        mul_check(32'd2, 32'd3, 1'b0, 64'd6, "after_abort");

        // back-to-back: new start accepted in the DONE cycle
        @(negedge clk);
        start = 1'b1; a = 32'd10; b = 32'd10; is_signed = 1'b0;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b first done", {63'd0, done}, 64'd1);
        chk("b2b first product", {hi, lo}, 64'd100);
        start = 1'b1; a = 32'd3; b = 32'd4;
        @(negedge clk);
        start = 1'b0;
        chk("b2b hilo held at capture", {hi, lo}, 64'd100);
        chk("b2b busy after restart", {63'd0, busy}, 64'd1);
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b spacing", 64'(lat), 64'd33);
        chk("b2b second product", {hi, lo}, 64'd12);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
